// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Fills the instruction memory from a framed byte stream and holds the core
// in reset until the image has been loaded.
//
// Frame: CNT_HI, CNT_LO (16-bit word count N, big-endian), then 4*N payload
// bytes with the most significant byte of each word first. When the macro
// BOOT_CHECKSUM_EN is defined, one trailing byte follows. It must equal the
// XOR of every byte from CNT_HI through the last payload byte.
//
// Handshake: a byte is accepted on a rising edge where rx_valid_i and
// rx_ready_o are both high. rx_ready_o is decoded from the state only. It is
// high while the image is being loaded and low once the loader is finished
// (DONE) or has rejected the image (ERR).
//
// Parameters:
//   MEM_WORDS  - instruction memory depth in words; largest legal N
//   BASE_ADDR  - byte address of the first loaded word (word aligned)
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   rx_data_i         - incoming byte
//   rx_valid_i        - rx_data_i valid this cycle
//   rx_ready_o        - loader can accept a byte
//   imem_we_o         - one-cycle instruction memory write strobe
//   imem_addr_o       - byte address of the write (BASE_ADDR + 4*index)
//   imem_wdata_o      - assembled instruction word
//   core_rst_n_o      - active-low core reset; released once the load is done
//   boot_done_o       - sticky; image loaded and accepted
//   boot_err_o        - sticky; image rejected
module imem_boot_loader #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        core_rst_n_o,
  output logic        boot_done_o,
  output logic        boot_err_o
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
`ifdef BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // The comparison is 17 bits wide so that a MEM_WORDS of 65536 still works.
  localparam logic [16:0] MAX_N = 17'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;      // word count N
  logic [15:0] idx_q, idx_d;      // index of the word being assembled
  logic [1:0]  bcnt_q, bcnt_d;    // byte position within the current word
  logic [23:0] word_q, word_d;    // first three bytes of the current word
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept;
  logic [15:0] hdr_n;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  localparam state_t S_AFTER_LOAD = S_CHK;
`else
  localparam state_t S_AFTER_LOAD = S_DONE;
`endif

  assign rx_ready_o = (state_q != S_DONE) && (state_q != S_ERR);
  assign accept     = rx_valid_i & rx_ready_o;
  assign hdr_n      = {cnt_q[15:8], rx_data_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // The status flags rise one edge after the terminal state is entered.
    done_d  = done_q | (state_q == S_DONE);
    err_d   = err_q | (state_q == S_ERR);
`ifdef BOOT_CHECKSUM_EN
    csum_d  = csum_q;
    if (accept && (state_q != S_CHK)) csum_d = csum_q ^ rx_data_i;
`endif
    case (state_q)
      S_HDR_HI: begin
        if (accept) begin
          cnt_d[15:8] = rx_data_i;
          state_d     = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          cnt_d[7:0] = rx_data_i;
          idx_d      = 16'd0;
          bcnt_d     = 2'd0;
          if ({1'b0, hdr_n} > MAX_N) state_d = S_ERR;
          else if (hdr_n == 16'd0)   state_d = S_AFTER_LOAD;
          else                       state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          bcnt_d = bcnt_q + 2'd1;
          word_d = {word_q[15:0], rx_data_i};
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {word_q, rx_data_i};
            addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
            idx_d   = idx_q + 16'd1;
            if (idx_q == cnt_q - 16'd1) state_d = S_AFTER_LOAD;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (rx_data_i == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: ;  // S_DONE and S_ERR hold until reset
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HDR_HI;
      cnt_q   <= 16'd0;
      idx_q   <= 16'd0;
      bcnt_q  <= 2'd0;
      word_q  <= 24'd0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign boot_done_o  = done_q;
  assign boot_err_o   = err_q;
  assign core_rst_n_o = done_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        boot_done;
  logic        boot_err;

  int checks = 0;
  int errors = 0;

  // Expected writes: {addr, data}
  logic [63:0] exp_q[$];

  imem_boot_loader #(.MEM_WORDS(256), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .core_rst_n_o (core_rst_n),
    .boot_done_o  (boot_done),
    .boot_err_o   (boot_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && imem_we === 1'b1) begin
      logic [63:0] e;
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e[63:32]);
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    // reset values while reset is asserted
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, BASE);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_done", 32'(boot_done), 32'd0);
    check("rst_err", 32'(boot_err), 32'd0);
    check("rst_ready", 32'(rx_ready), 32'd1);
    idle(2);
    rst = 1'b0;
    check("ready_after_rst", 32'(rx_ready), 32'd1);

    // ---- nominal two-word frame, back-to-back ----
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00);
    push_write(BASE + 32'd0, 32'h2008_0005);
    send_byte(8'h05);
    check("nom_core_held", 32'(core_rst_n), 32'd0);
    send_byte(8'h21); send_byte(8'h09); send_byte(8'h00);
    push_write(BASE + 32'd4, 32'h2109_0003);
    send_byte(8'h03);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h04);
`endif
    check("nom_done_not_yet", 32'(boot_done), 32'd0);
    idle(1);
    check("nom_done", 32'(boot_done), 32'd1);
    check("nom_core_rst_n", 32'(core_rst_n), 32'd1);
    check("nom_err", 32'(boot_err), 32'd0);
    check("nom_ready_low", 32'(rx_ready), 32'd0);
    // bytes in DONE are ignored and cause no write
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    idle(2);
    check("nom_done_sticky", 32'(boot_done), 32'd1);
    check("nom_writes_drained", 32'(exp_q.size()), 32'd0);

`ifdef BOOT_CHECKSUM_EN
    // ---- bad checksum ----
    do_reset();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00);
    push_write(BASE + 32'd0, 32'h2008_0005);
    send_byte(8'h05);
    send_byte(8'h21); send_byte(8'h09); send_byte(8'h00);
    push_write(BASE + 32'd4, 32'h2109_0003);
    send_byte(8'h03);
    send_byte(8'h05);
    idle(1);
    check("csum_err", 32'(boot_err), 32'd1);
    check("csum_core_held", 32'(core_rst_n), 32'd0);
    check("csum_not_done", 32'(boot_done), 32'd0);
    check("csum_writes_drained", 32'(exp_q.size()), 32'd0);
`endif

    // ---- oversize header ----
    do_reset();
    send_byte(8'h01); send_byte(8'h01);
    check("over_ready_low", 32'(rx_ready), 32'd0);
    idle(1);
    check("over_err", 32'(boot_err), 32'd1);
    check("over_core_held", 32'(core_rst_n), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)));
    check("over_err_sticky", 32'(boot_err), 32'd1);
    check("over_no_done", 32'(boot_done), 32'd0);

    // ---- largest legal header does not error ----
    do_reset();
    send_byte(8'h01); send_byte(8'h00);
    idle(2);
    check("max_n_no_err", 32'(boot_err), 32'd0);
    check("max_n_ready", 32'(rx_ready), 32'd1);

    // ---- zero length ----
    do_reset();
    send_byte(8'h00); send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00);
`endif
    check("zero_done_not_yet", 32'(boot_done), 32'd0);
    idle(1);
    check("zero_done", 32'(boot_done), 32'd1);
    check("zero_core_rst_n", 32'(core_rst_n), 32'd1);

    // ---- gapped one-word frame ----
    do_reset();
    send_byte(8'h00); idle(2);
    send_byte(8'h01); idle(2);
    send_byte(8'h12); idle(2);
    send_byte(8'h34); idle(2);
    send_byte(8'h56); idle(2);
    push_write(BASE, 32'h1234_5678);
    send_byte(8'h78); idle(2);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h09); idle(2);
`endif
    check("gap_done", 32'(boot_done), 32'd1);
    check("gap_writes_drained", 32'(exp_q.size()), 32'd0);

    // ---- reset mid-load ----
    do_reset();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    push_write(BASE, 32'h1122_3344);
    send_byte(8'h44);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_we_dropped", 32'(imem_we), 32'd0);
    check("midrst_wdata", imem_wdata, 32'd0);
    check("midrst_ready", 32'(rx_ready), 32'd1);
    idle(2);
    rst = 1'b0;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    push_write(BASE, 32'hAABB_CCDD);
    send_byte(8'hDD);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h01);
`endif
    idle(1);
    check("midrst_done", 32'(boot_done), 32'd1);
    check("midrst_err", 32'(boot_err), 32'd0);
    idle(2);
    check("final_writes_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
